tran_switch_arbiter: RTL and testbench



---
 rtl/tran_switch_arbiter.sv | 166 ++++++++++++++++
 tb/tb_tran_switch_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tran_switch_arbiter.sv
// Round-robin owner of a shared bidirectional segment: drives per-requester pass-switch
// enables with break-before-make dead time, settle delay and optional hold timeout.
//
// state  | meaning
// IDLE   | all switches open, waiting for any request
// SETTLE | winner's switch closed, waiting for the path to settle
// OWN    | bus valid, owner granted
// BREAK  | all switches open for the dead time before the next owner
module tran_switch_arbiter #(
    parameter int N          = 4,
    parameter int SETTLE_CYC = 2,
    parameter int DEAD_CYC   = 1,
    parameter int MAX_HOLD   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         sw_en,
    output logic [N-1:0]         gnt,
    output logic                 bus_valid,
    output logic [$clog2(N)-1:0] owner_id,
    output logic                 timeout_pulse
);

    localparam int IW   = $clog2(N);
    localparam int CMAX = (SETTLE_CYC > DEAD_CYC) ? SETTLE_CYC : DEAD_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int HW   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] DEAD_LOAD   = CW'(DEAD_CYC - 1);
    localparam logic [HW-1:0] HOLD_MAX    = HW'(MAX_HOLD);
    // The first OWN cycle already counts as one held cycle.
    localparam logic [HW-1:0] HOLD_START  = HW'((MAX_HOLD != 0) ? 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OWN    = 2'd2,
        BREAK  = 2'd3
    } state_t;

    state_t         state;
    logic [IW-1:0]  ptr;
    logic [CW-1:0]  cnt;
    logic [HW-1:0]  hold;

    logic           pick_any;
    logic [IW-1:0]  pick_id;
    logic           found;
    int             idx;
    logic [IW-1:0]  ptr_next;
    logic           contention;
    logic           owner_req;

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] id);
        logic [N-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Rotating priority search starting at ptr.
    always_comb begin
        pick_id = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found   = 1'b1;
                pick_id = IW'(idx);
            end
        end
        pick_any = found;
    end

    always_comb begin
        ptr_next   = (owner_id == IW'(N - 1)) ? '0 : owner_id + 1'b1;
        contention = (req & ~sw_en) != '0;
        owner_req  = req[owner_id];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            cnt           <= '0;
            hold          <= '0;
            sw_en         <= '0;
            gnt           <= '0;
            bus_valid     <= 1'b0;
            owner_id      <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state    <= SETTLE;
                        sw_en    <= onehot(pick_id);
                        owner_id <= pick_id;
                        cnt      <= SETTLE_LOAD;
                    end
                end

                SETTLE: begin
                    if (!owner_req) begin
                        state <= BREAK;
                        sw_en <= '0;
                        ptr   <= ptr_next;
                        hold  <= '0;
                        cnt   <= DEAD_LOAD;
                    end else if (cnt == '0) begin
                        state     <= OWN;
                        gnt       <= sw_en;
                        bus_valid <= 1'b1;
                        hold      <= HOLD_START;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                OWN: begin
                    // A release on the same edge as a timeout wins, so no pulse then.
                    if (!owner_req ||
                        ((MAX_HOLD != 0) && (hold == HOLD_MAX) && contention)) begin
                        state         <= BREAK;
                        sw_en         <= '0;
                        gnt           <= '0;
                        bus_valid     <= 1'b0;
                        ptr           <= ptr_next;
                        hold          <= '0;
                        cnt           <= DEAD_LOAD;
                        timeout_pulse <= owner_req;
                    end else if (hold != HOLD_MAX) begin
                        hold <= hold + 1'b1;
                    end
                end

                BREAK: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (pick_any) begin
                        state    <= SETTLE;
                        sw_en    <= onehot(pick_id);
                        owner_id <= pick_id;
                        cnt      <= SETTLE_LOAD;
                    end else begin
                        state    <= IDLE;
                        owner_id <= '0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    sw_en     <= '0;
                    gnt       <= '0;
                    bus_valid <= 1'b0;
                    owner_id  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tran_switch_arbiter.sv
// Scoreboard bench for tran_switch_arbiter: stimulus pushes cycle-tagged expectations,
// a negedge monitor pops and compares them and checks per-cycle invariants.
module tb_tran_switch_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] sw_en;
    logic [3:0] gnt;
    logic       bus_valid;
    logic [1:0] owner_id;
    logic       timeout_pulse;

    int n_tests = 0;
    int n_fail  = 0;
    int ecount  = 0;

    typedef struct {
        int         cyc;
        logic [3:0] sw;
        logic [3:0] g;
        logic       bv;
        logic [1:0] id;
        logic       tp;
        string      nm;
    } exp_t;

    exp_t q[$];

    tran_switch_arbiter #(
        .N(4), .SETTLE_CYC(2), .DEAD_CYC(1), .MAX_HOLD(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .sw_en(sw_en),
        .gnt(gnt),
        .bus_valid(bus_valid),
        .owner_id(owner_id),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecount <= ecount + 1;

    function automatic void push(input int c, input logic [3:0] sw, input logic [3:0] g,
                                 input logic bv, input logic [1:0] id, input logic tp,
                                 input string nm);
        exp_t e;
        e.cyc = c; e.sw = sw; e.g = g; e.bv = bv; e.id = id; e.tp = tp; e.nm = nm;
        q.push_back(e);
    endfunction

    // Monitor: outputs are stable at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        logic tp_ok;
        tp_ok = 1'b0;
        while (q.size() > 0 && q[0].cyc <= ecount) begin
            e = q.pop_front();
            n_tests++;
            if (e.cyc < ecount) begin
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d skipped (now %0d)", e.nm, e.cyc, ecount);
            end else begin
                if (e.tp) tp_ok = 1'b1;
                if ({sw_en, gnt, bus_valid, owner_id, timeout_pulse} !==
                    {e.sw, e.g, e.bv, e.id, e.tp}) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got sw=%b gnt=%b bv=%b id=%0d tp=%b want sw=%b gnt=%b bv=%b id=%0d tp=%b",
                             e.nm, ecount, sw_en, gnt, bus_valid, owner_id, timeout_pulse,
                             e.sw, e.g, e.bv, e.id, e.tp);
                end
            end
        end
        n_tests++;
        if ($countones(sw_en) > 1 || gnt !== (bus_valid ? sw_en : 4'b0000) ||
            (timeout_pulse && !tp_ok)) begin
            n_fail++;
            $display("FAIL invariant cyc=%0d got sw=%b gnt=%b bv=%b tp=%b want onehot0 sw, gnt=sw&bv, tp only when expected",
                     ecount, sw_en, gnt, bus_valid, timeout_pulse);
        end
    end

    initial begin
        int t;
        rst_n = 1'b0;
        req   = 4'b1111;
        @(negedge clk);
        push(ecount + 1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "reset_hold_a");
        push(ecount + 2, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "reset_hold_b");
        repeat (3) @(negedge clk);

        // Reset release and first grant
        rst_n = 1'b1;
        t = ecount;
        push(t + 1, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0, "first_settle");
        push(t + 2, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0, "first_settle_b");
        push(t + 3, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0, "first_grant");
        repeat (4) @(negedge clk);

        // Release and rotation 0 -> 1 -> 3
        req = 4'b1010;
        t = ecount;
        push(t + 1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "break_gap0");
        push(t + 2, 4'b0010, 4'b0000, 1'b0, 2'd1, 1'b0, "settle_owner1");
        push(t + 4, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0, "grant_owner1");
        repeat (5) @(negedge clk);
        req = 4'b1000;
        t = ecount;
        push(t + 1, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0, "break_owner1");
        push(t + 2, 4'b1000, 4'b0000, 1'b0, 2'd3, 1'b0, "settle_owner3");
        push(t + 4, 4'b1000, 4'b1000, 1'b1, 2'd3, 1'b0, "grant_owner3");
        repeat (5) @(negedge clk);
        req = 4'b0000;
        t = ecount;
        push(t + 2, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "idle_after3");
        repeat (3) @(negedge clk);

        // Timeout under contention
        req = 4'b0101;
        t = ecount;
        push(t + 3,  4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0, "own0_start");
        push(t + 18, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0, "own0_16th");
        push(t + 19, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, "timeout_break");
        push(t + 20, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b0, "settle_owner2");
        push(t + 21, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b0, "settle_owner2_b");
        push(t + 22, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0, "grant_owner2");
        repeat (23) @(negedge clk);

        // No contention: owner 0 keeps the bus for 40 cycles
        req = 4'b0001;
        t = ecount;
        push(t + 1, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, "break_owner2");
        push(t + 2, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0, "settle_owner0");
        for (int i = 4; i < 44; i++)
            push(t + i, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0, "hold_no_contention");
        repeat (44) @(negedge clk);

        // SETTLE abort
        req = 4'b0010;
        t = ecount;
        push(t + 1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "break_owner0");
        push(t + 2, 4'b0010, 4'b0000, 1'b0, 2'd1, 1'b0, "abort_settle");
        repeat (2) @(negedge clk);
        req = 4'b0000;
        push(t + 3, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0, "abort_break");
        push(t + 4, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "abort_idle");
        push(t + 5, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "abort_idle_b");
        repeat (4) @(negedge clk);

        // Move ptr to 3 with owner 3 in OWN, then reset asynchronously
        req = 4'b0100;
        t = ecount;
        push(t + 3, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0, "own2_pre");
        repeat (4) @(negedge clk);
        req = 4'b1000;
        t = ecount;
        push(t + 1, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, "break2_pre");
        push(t + 2, 4'b1000, 4'b0000, 1'b0, 2'd3, 1'b0, "settle3_pre");
        push(t + 4, 4'b1000, 4'b1000, 1'b1, 2'd3, 1'b0, "own3_pre_reset");
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({sw_en, gnt, bus_valid, owner_id, timeout_pulse} !== 12'd0) begin
            n_fail++;
            $display("FAIL async_reset got sw=%b gnt=%b bv=%b id=%0d tp=%b want all 0",
                     sw_en, gnt, bus_valid, owner_id, timeout_pulse);
        end
        req = 4'b1100;
        @(negedge clk);
        rst_n = 1'b1;
        t = ecount;
        push(t + 1, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b0, "restart_settle");
        push(t + 3, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0, "restart_grant");
        repeat (6) @(negedge clk);

        #1;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
